// File: rtl/split_scheduler_if.sv
// rtl/split_scheduler_if.sv - hit, spawn and kill signal bundle for split_scheduler
// master is the game side that reports hits and loads balls; slave is the scheduler.
interface split_scheduler_if #(
   parameter int NUM_SLOTS = 8
);
   localparam int SLOT_W = $clog2(NUM_SLOTS);

   logic              hit_valid;
   logic              hit_ready;
   logic [SLOT_W-1:0] hit_slot;
   shortint           Xspeed;
   shortint           Yspeed;

   logic              spawn_valid;
   logic              spawn_ready;
   logic [SLOT_W-1:0] spawn_slot;
   logic [1:0]        spawn_size;
   shortint           spawn_xspeed;
   shortint           spawn_yspeed;

   logic              kill_pulse;
   logic [SLOT_W-1:0] kill_slot;

   modport master (
      output hit_valid, hit_slot, Xspeed, Yspeed, spawn_ready,
      input  hit_ready, spawn_valid, spawn_slot, spawn_size, spawn_xspeed, spawn_yspeed,
      input  kill_pulse, kill_slot
   );

   modport slave (
      input  hit_valid, hit_slot, Xspeed, Yspeed, spawn_ready,
      output hit_ready, spawn_valid, spawn_slot, spawn_size, spawn_xspeed, spawn_yspeed,
      output kill_pulse, kill_slot
   );
endinterface

// File: rtl/split_scheduler.sv
// rtl/split_scheduler.sv - ball-pool split scheduler: hit -> two children or a kill
// Optional SPLIT_STATS_EN adds saturating drop_count / pop_count outputs.
module split_scheduler #(
   parameter int NUM_SLOTS = 8,
   parameter int MAX_SIZE  = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   split_scheduler_if.slave     bus,
   output logic [NUM_SLOTS-1:0] alive,
   output logic                 level_clear
`ifdef SPLIT_STATS_EN
   ,
   output logic [15:0]          drop_count,
   output logic [15:0]          pop_count
`endif
);
   localparam int SLOT_W   = $clog2(NUM_SLOTS);
   localparam int SLOTS_P2 = 1 << SLOT_W;

   typedef enum logic [1:0] {IDLE, SPAWN1, SPAWN2, KILL} state_t;

   state_t                      state_q, state_d;
   logic [NUM_SLOTS-1:0]        alive_q, alive_d;
   logic [NUM_SLOTS-1:0][1:0]   size_q, size_d;
   logic [SLOT_W-1:0]           slot_q, slot_d, free_slot_q, free_slot_d;
   logic                        free_ok_q, free_ok_d;
   logic [1:0]                  csize_q, csize_d;
   shortint                     x_q, x_d, y_q, y_d;
   logic                        armed_q, armed_d, level_clear_q;
`ifdef SPLIT_STATS_EN
   logic [15:0]                 drop_q, drop_d, pop_q, pop_d;
`endif

   logic [SLOTS_P2-1:0]         alive_ext;
   logic                        hit_live, free_found;
   logic [SLOT_W-1:0]           free_idx;
   logic [1:0]                  child_size;
   shortint                     y_child, x_mirror;

   logic                        hit_ready_w, spawn_valid_w, kill_pulse_w;
   logic [SLOT_W-1:0]           spawn_slot_w, kill_slot_w;
   logic [1:0]                  spawn_size_w;
   shortint                     spawn_x_w, spawn_y_w;

   // Padding to a power of two makes out-of-range slot indices read as dead.
   assign alive_ext  = SLOTS_P2'(alive_q);
   assign hit_live   = alive_ext[bus.hit_slot];
   assign child_size = csize_q - 2'd1;
   assign y_child    = (y_q < 0) ? y_q : shortint'(-y_q);
   assign x_mirror   = (x_q == shortint'(16'h8000)) ? shortint'(16'h7FFF) : shortint'(-x_q);

   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (!alive_q[i]) begin
            free_found = 1'b1;
            free_idx   = SLOT_W'(i);
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      alive_d       = alive_q;
      size_d        = size_q;
      slot_d        = slot_q;
      free_slot_d   = free_slot_q;
      free_ok_d     = free_ok_q;
      csize_d       = csize_q;
      x_d           = x_q;
      y_d           = y_q;
      armed_d       = armed_q;
      hit_ready_w   = 1'b0;
      spawn_valid_w = 1'b0;
      spawn_slot_w  = '0;
      spawn_size_w  = '0;
      spawn_x_w     = '0;
      spawn_y_w     = '0;
      kill_pulse_w  = 1'b0;
      kill_slot_w   = '0;
`ifdef SPLIT_STATS_EN
      drop_d        = drop_q;
      pop_d         = pop_q;
`endif
      case (state_q)
         IDLE: begin
            hit_ready_w = 1'b1;
            // start wins over a same-cycle hit; that hit is consumed with no effect
            if (start) begin
               alive_d    = '0;
               alive_d[0] = 1'b1;
               size_d     = '0;
               size_d[0]  = 2'(MAX_SIZE);
               armed_d    = 1'b1;
`ifdef SPLIT_STATS_EN
               drop_d     = '0;
               pop_d      = '0;
`endif
            end else if (bus.hit_valid && hit_live) begin
               slot_d  = bus.hit_slot;
               x_d     = bus.Xspeed;
               y_d     = bus.Yspeed;
               csize_d = size_q[bus.hit_slot];
               state_d = (size_q[bus.hit_slot] == 2'd0) ? KILL : SPAWN1;
            end
         end
         SPAWN1: begin
            spawn_valid_w = 1'b1;
            spawn_slot_w  = slot_q;
            spawn_size_w  = child_size;
            spawn_x_w     = x_q;
            spawn_y_w     = y_child;
            if (bus.spawn_ready) begin
               size_d[slot_q] = child_size;
               free_slot_d    = free_idx;
               free_ok_d      = free_found;
               state_d        = SPAWN2;
            end
         end
         SPAWN2: begin
            if (free_ok_q) begin
               spawn_valid_w = 1'b1;
               spawn_slot_w  = free_slot_q;
               spawn_size_w  = child_size;
               spawn_x_w     = x_mirror;
               spawn_y_w     = y_child;
               if (bus.spawn_ready) begin
                  alive_d[free_slot_q] = 1'b1;
                  size_d[free_slot_q]  = child_size;
                  state_d              = IDLE;
               end
            end else begin
               state_d = IDLE;
`ifdef SPLIT_STATS_EN
               if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
`endif
            end
         end
         KILL: begin
            kill_pulse_w    = 1'b1;
            kill_slot_w     = slot_q;
            alive_d[slot_q] = 1'b0;
            state_d         = IDLE;
`ifdef SPLIT_STATS_EN
            if (pop_q != 16'hFFFF) pop_d = pop_q + 16'd1;
`endif
         end
         default: state_d = IDLE;
      endcase
      if (reset) begin
         hit_ready_w   = 1'b0;
         spawn_valid_w = 1'b0;
         spawn_slot_w  = '0;
         spawn_size_w  = '0;
         spawn_x_w     = '0;
         spawn_y_w     = '0;
         kill_pulse_w  = 1'b0;
         kill_slot_w   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         alive_q       <= '0;
         size_q        <= '0;
         slot_q        <= '0;
         free_slot_q   <= '0;
         free_ok_q     <= 1'b0;
         csize_q       <= '0;
         x_q           <= '0;
         y_q           <= '0;
         armed_q       <= 1'b0;
         level_clear_q <= 1'b0;
`ifdef SPLIT_STATS_EN
         drop_q        <= '0;
         pop_q         <= '0;
`endif
      end else begin
         state_q       <= state_d;
         alive_q       <= alive_d;
         size_q        <= size_d;
         slot_q        <= slot_d;
         free_slot_q   <= free_slot_d;
         free_ok_q     <= free_ok_d;
         csize_q       <= csize_d;
         x_q           <= x_d;
         y_q           <= y_d;
         armed_q       <= armed_d;
         level_clear_q <= armed_q && (alive_q == '0);
`ifdef SPLIT_STATS_EN
         drop_q        <= drop_d;
         pop_q         <= pop_d;
`endif
      end
   end

   assign bus.hit_ready    = hit_ready_w;
   assign bus.spawn_valid  = spawn_valid_w;
   assign bus.spawn_slot   = spawn_slot_w;
   assign bus.spawn_size   = spawn_size_w;
   assign bus.spawn_xspeed = spawn_x_w;
   assign bus.spawn_yspeed = spawn_y_w;
   assign bus.kill_pulse   = kill_pulse_w;
   assign bus.kill_slot    = kill_slot_w;
   assign alive            = alive_q;
   assign level_clear      = level_clear_q;
`ifdef SPLIT_STATS_EN
   assign drop_count       = drop_q;
   assign pop_count        = pop_q;
`endif
endmodule

// File: tb/tb_split_scheduler.sv
// tb/tb_split_scheduler.sv - directed bench for split_scheduler on a 4-slot pool
// A 4-slot pool is used so that a full pool with a splittable ball is reachable.
module tb_split_scheduler;
   localparam int NS = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [NS-1:0] alive;
   logic          level_clear;
`ifdef SPLIT_STATS_EN
   logic [15:0]   drop_count;
   logic [15:0]   pop_count;
`endif
   int            checks = 0;
   int            errors = 0;
   logic [36:0]   act_sp;
   logic [36:0]   exp_sp;

   split_scheduler_if #(.NUM_SLOTS(NS)) bus ();

   split_scheduler #(.NUM_SLOTS(NS), .MAX_SIZE(3)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .bus         (bus),
      .alive       (alive),
      .level_clear (level_clear)
`ifdef SPLIT_STATS_EN
      ,
      .drop_count  (drop_count),
      .pop_count   (pop_count)
`endif
   );

   always #5 clk = ~clk;

   assign act_sp = {bus.spawn_valid, bus.spawn_slot, bus.spawn_size, bus.spawn_xspeed, bus.spawn_yspeed};

   function automatic logic [36:0] sp(input logic v, input logic [1:0] s, input logic [1:0] z,
                                      input shortint x, input shortint y);
      return {v, s, z, x, y};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_hit(input logic [1:0] slot, input shortint x, input shortint y);
      bus.hit_valid = 1'b1;
      bus.hit_slot  = slot;
      bus.Xspeed    = x;
      bus.Yspeed    = y;
      tick();
      bus.hit_valid = 1'b0;
   endtask

   task automatic do_hit(input logic [1:0] slot);
      drive_hit(slot, 16'sd1, 16'sd1);
      for (int n = 0; n < 6 && !bus.hit_ready; n++) tick();
      checks++;
      if (bus.hit_ready !== 1'b1) begin
         errors++;
         $display("FAIL do_hit_timeout slot %0d hit_ready got %b want 1", slot, bus.hit_ready);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      checks++; if (alive !== 4'b0000) begin errors++; $display("FAIL rst_alive got %b want 0000", alive); end
      checks++; if (bus.hit_ready !== 1'b0) begin errors++; $display("FAIL rst_hit_ready got %b want 0", bus.hit_ready); end
      checks++; if (act_sp !== 37'd0) begin errors++; $display("FAIL rst_spawn got %h want 0", act_sp); end
      checks++; if ({bus.kill_pulse, bus.kill_slot} !== 3'b000) begin errors++; $display("FAIL rst_kill got %b want 000", {bus.kill_pulse, bus.kill_slot}); end
      checks++; if (level_clear !== 1'b0) begin errors++; $display("FAIL rst_level_clear got %b want 0", level_clear); end
      reset = 1'b0;
      #1;
      checks++; if (bus.hit_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b want 1", bus.hit_ready); end
   endtask

   task automatic test_split();
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++; if (alive !== 4'b0001) begin errors++; $display("FAIL start_alive got %b want 0001", alive); end
      drive_hit(2'd0, 16'sd5, 16'sd3);
      exp_sp = sp(1'b1, 2'd0, 2'd2, 16'sd5, -16'sd3);
      checks++; if (act_sp !== exp_sp) begin errors++; $display("FAIL split_spawn1 got %h want %h", act_sp, exp_sp); end
      checks++; if (bus.hit_ready !== 1'b0) begin errors++; $display("FAIL split_busy got %b want 0", bus.hit_ready); end
      tick();
      exp_sp = sp(1'b1, 2'd1, 2'd2, -16'sd5, -16'sd3);
      checks++; if (act_sp !== exp_sp) begin errors++; $display("FAIL split_spawn2 got %h want %h", act_sp, exp_sp); end
      tick();
      checks++; if (alive !== 4'b0011) begin errors++; $display("FAIL split_alive got %b want 0011", alive); end
      checks++; if ({bus.hit_ready, bus.spawn_valid} !== 2'b10) begin errors++; $display("FAIL split_idle got %b want 10", {bus.hit_ready, bus.spawn_valid}); end
   endtask

   task automatic test_saturate();
      drive_hit(2'd1, shortint'(16'h8000), -16'sd7);
      exp_sp = sp(1'b1, 2'd1, 2'd1, shortint'(16'h8000), -16'sd7);
      checks++; if (act_sp !== exp_sp) begin errors++; $display("FAIL sat_spawn1 got %h want %h", act_sp, exp_sp); end
      tick();
      exp_sp = sp(1'b1, 2'd2, 2'd1, 16'sd32767, -16'sd7);
      checks++; if (act_sp !== exp_sp) begin errors++; $display("FAIL sat_spawn2 got %h want %h", act_sp, exp_sp); end
      tick();
      checks++; if (alive !== 4'b0111) begin errors++; $display("FAIL sat_alive got %b want 0111", alive); end
   endtask

   task automatic test_stall();
      bus.spawn_ready = 1'b0;
      drive_hit(2'd0, 16'sd100, -16'sd20);
      exp_sp = sp(1'b1, 2'd0, 2'd1, 16'sd100, -16'sd20);
      for (int c = 0; c < 5; c++) begin
         checks++; if ({act_sp, bus.hit_ready} !== {exp_sp, 1'b0}) begin errors++; $display("FAIL stall_cycle%0d got %h want %h", c, {act_sp, bus.hit_ready}, {exp_sp, 1'b0}); end
         tick();
      end
      bus.spawn_ready = 1'b1;
      tick();
      exp_sp = sp(1'b1, 2'd3, 2'd1, -16'sd100, -16'sd20);
      checks++; if (act_sp !== exp_sp) begin errors++; $display("FAIL stall_spawn2 got %h want %h", act_sp, exp_sp); end
      tick();
      checks++; if (alive !== 4'b1111) begin errors++; $display("FAIL stall_alive got %b want 1111", alive); end
   endtask

   task automatic test_pool_full();
      drive_hit(2'd2, 16'sd1, 16'sd1);
      exp_sp = sp(1'b1, 2'd2, 2'd0, 16'sd1, -16'sd1);
      checks++; if (act_sp !== exp_sp) begin errors++; $display("FAIL full_spawn1 got %h want %h", act_sp, exp_sp); end
      tick();
      checks++; if ({act_sp, bus.hit_ready} !== 38'd0) begin errors++; $display("FAIL full_spawn2_idle got %h want 0", {act_sp, bus.hit_ready}); end
      tick();
      checks++; if ({alive, bus.hit_ready} !== 5'b11111) begin errors++; $display("FAIL full_after got %b want 11111", {alive, bus.hit_ready}); end
`ifdef SPLIT_STATS_EN
      checks++; if (drop_count !== 16'd1) begin errors++; $display("FAIL full_drop_count got %0d want 1", drop_count); end
`endif
   endtask

   task automatic test_kill();
      drive_hit(2'd2, 16'sd1, 16'sd1);
      checks++; if ({bus.kill_pulse, bus.kill_slot, alive} !== {1'b1, 2'd2, 4'b1111}) begin errors++; $display("FAIL kill_pulse got %b want 1101111", {bus.kill_pulse, bus.kill_slot, alive}); end
      checks++; if (bus.spawn_valid !== 1'b0) begin errors++; $display("FAIL kill_no_spawn got %b want 0", bus.spawn_valid); end
      tick();
      checks++; if ({bus.kill_pulse, alive, bus.hit_ready} !== {1'b0, 4'b1011, 1'b1}) begin errors++; $display("FAIL kill_after got %b want 0_1011_1", {bus.kill_pulse, alive, bus.hit_ready}); end
`ifdef SPLIT_STATS_EN
      checks++; if (pop_count !== 16'd1) begin errors++; $display("FAIL kill_pop_count got %0d want 1", pop_count); end
`endif
   endtask

   task automatic test_dead_hit();
      drive_hit(2'd2, 16'sd4, 16'sd4);
      checks++; if ({bus.hit_ready, bus.spawn_valid, bus.kill_pulse, alive} !== {3'b100, 4'b1011}) begin errors++; $display("FAIL dead_hit got %b want 1001011", {bus.hit_ready, bus.spawn_valid, bus.kill_pulse, alive}); end
      tick();
      checks++; if ({bus.kill_pulse, alive} !== {1'b0, 4'b1011}) begin errors++; $display("FAIL dead_hit_later got %b want 01011", {bus.kill_pulse, alive}); end
   endtask

   task automatic test_start_in_spawn2();
      drive_hit(2'd3, 16'sd2, 16'sd2);
      exp_sp = sp(1'b1, 2'd3, 2'd0, 16'sd2, -16'sd2);
      checks++; if (act_sp !== exp_sp) begin errors++; $display("FAIL s2start_spawn1 got %h want %h", act_sp, exp_sp); end
      tick();
      exp_sp = sp(1'b1, 2'd2, 2'd0, -16'sd2, -16'sd2);
      checks++; if (act_sp !== exp_sp) begin errors++; $display("FAIL s2start_spawn2 got %h want %h", act_sp, exp_sp); end
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++; if (alive !== 4'b1111) begin errors++; $display("FAIL s2start_alive got %b want 1111", alive); end
      tick();
      checks++; if ({alive, level_clear} !== 5'b11110) begin errors++; $display("FAIL s2start_later got %b want 11110", {alive, level_clear}); end
   endtask

   task automatic test_level_clear();
      do_hit(2'd2);
      do_hit(2'd3);
      do_hit(2'd0);
      do_hit(2'd1);
      do_hit(2'd0);
      do_hit(2'd1);
      do_hit(2'd2);
      checks++; if ({alive, level_clear} !== 5'b10000) begin errors++; $display("FAIL lc_before got %b want 10000", {alive, level_clear}); end
      drive_hit(2'd3, 16'sd1, 16'sd1);
      checks++; if ({bus.kill_pulse, bus.kill_slot, level_clear} !== 4'b1110) begin errors++; $display("FAIL lc_kill got %b want 1110", {bus.kill_pulse, bus.kill_slot, level_clear}); end
      tick();
      checks++; if ({alive, level_clear} !== 5'b00000) begin errors++; $display("FAIL lc_alive_zero got %b want 00000", {alive, level_clear}); end
      tick();
      checks++; if (level_clear !== 1'b1) begin errors++; $display("FAIL lc_set got %b want 1", level_clear); end
`ifdef SPLIT_STATS_EN
      checks++; if ({drop_count, pop_count} !== {16'd1, 16'd7}) begin errors++; $display("FAIL lc_stats got %0d/%0d want 1/7", drop_count, pop_count); end
`endif
   endtask

   task automatic test_reset_mid();
      start = 1'b1;
      tick();
      start = 1'b0;
      bus.spawn_ready = 1'b0;
      drive_hit(2'd0, 16'sd9, 16'sd4);
      exp_sp = sp(1'b1, 2'd0, 2'd2, 16'sd9, -16'sd4);
      for (int c = 0; c < 2; c++) begin
         checks++; if (act_sp !== exp_sp) begin errors++; $display("FAIL rmid_cycle%0d got %h want %h", c, act_sp, exp_sp); end
         tick();
      end
      reset = 1'b1;
      #1;
      checks++; if ({bus.spawn_valid, bus.hit_ready} !== 2'b00) begin errors++; $display("FAIL rmid_in_reset got %b want 00", {bus.spawn_valid, bus.hit_ready}); end
      tick();
      checks++; if ({alive, level_clear} !== 5'b00000) begin errors++; $display("FAIL rmid_alive got %b want 00000", {alive, level_clear}); end
      reset = 1'b0;
      #1;
      checks++; if ({bus.hit_ready, bus.spawn_valid} !== 2'b10) begin errors++; $display("FAIL rmid_release got %b want 10", {bus.hit_ready, bus.spawn_valid}); end
`ifdef SPLIT_STATS_EN
      checks++; if ({drop_count, pop_count} !== 32'd0) begin errors++; $display("FAIL rmid_stats got %0d/%0d want 0/0", drop_count, pop_count); end
`endif
      bus.spawn_ready = 1'b1;
   endtask

   initial begin
      reset           = 1'b1;
      start           = 1'b0;
      bus.hit_valid   = 1'b0;
      bus.hit_slot    = '0;
      bus.Xspeed      = '0;
      bus.Yspeed      = '0;
      bus.spawn_ready = 1'b1;
      test_reset();
      test_split();
      test_saturate();
      test_stall();
      test_pool_full();
      test_kill();
      test_dead_hit();
      test_start_in_spawn2();
      test_level_clear();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
